// File: rtl/reg_file_port_arbiter.sv
// Shares the register file's write port and read port 1 between NREQ requesters (round-robin; fixed priority with ARB_FIXED_PRIO_EN).
// Latency: req sampled in IDLE -> ack two cycles later; at most one transaction per three cycles.
// Backpressure: requesters hold req and payload until their one-cycle ack; the payload is latched at grant.
module reg_file_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic [AW-1:0]      mem_rd_addr,
    output logic [AW-1:0]      mem_wr_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_mode,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state;
    logic [PW-1:0]  gnt_idx;
    logic           op_wr;

    logic           win_found;
    logic [PW-1:0]  win_idx;
    logic           win_wr;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_wdata;

`ifdef ARB_FIXED_PRIO_EN
    // Descending scan leaves the lowest requesting index as the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] ptr;
    logic [PW:0]   cand;

    // Scan from ptr upward modulo NREQ; descending k lets the nearest requester win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == IDLE && win_found) begin
            ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end
`endif

    always_comb begin
        win_wr    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                win_wr    = req_wr[i];
                win_addr  = req_addr[i*AW +: AW];
                win_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // mem_mode is a plain register so an asynchronous reset kills an in-flight write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_idx     <= '0;
            op_wr       <= 1'b0;
            ack         <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_addr <= '0;
            mem_wdata   <= '0;
            mem_mode    <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_idx     <= win_idx;
                        op_wr       <= win_wr;
                        mem_rd_addr <= win_addr;
                        mem_wr_addr <= win_addr;
                        if (win_wr) begin
                            mem_wdata <= win_wdata;
                        end
                        mem_mode    <= win_wr;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_mode <= 1'b0;
                    if (!op_wr) begin
                        rdata <= mem_rdata;
                    end
                    ack[gnt_idx] <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_mode <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
